// File: rtl/video_stream_gate.sv
// video_stream_gate
//   Avalon-ST video pass-through with frame-accurate pause, single-frame step,
//   full backpressure and per-frame statistics/IRQ, controlled over Avalon-MM.
//   Input is only gated between frames; the output pipeline always drains.
//
//   Optional feature macro: VSG_SIZE_CHECK_EN (EXPECT_PIXELS register, size_err
//   status bit, ctrl[10] irq enable). Undefined by default.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   chipselect/address/write/writedata/read/readdata   Avalon-MM slave (read latency 1)
//   irq_sender                 level interrupt
//   valid_in/ready_out/data_in/startofpacket_in/endofpacket_in       ST sink
//   valid_out/ready_in/data_out/startofpacket_out/endofpacket_out    ST source
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RUN    | pass-through, input open
// S_WAIT   | pause requested mid-frame, input open until the frame's eop
// S_PAUSED | input closed between frames, pipeline still drains
// S_STEP   | input open for exactly one frame, then back to S_PAUSED
module video_stream_gate #(
   parameter int DATA_W     = 16,
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic [2:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic              irq_sender,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [DATA_W-1:0] data_in,
   input  logic              startofpacket_in,
   input  logic              endofpacket_in,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              startofpacket_out,
   output logic              endofpacket_out
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_PAUSED, S_STEP} state_t;
   state_t state, state_nxt;

   logic [PIPE_DEPTH-1:0] pv, ps, pe;
   logic [DATA_W-1:0]     pd [PIPE_DEPTH];

   logic adv, gate_open, acc, acc_sop, acc_eop;
   logic in_frame, in_frame_nxt, step_frame;
   logic pause_req;
   logic [1:0] irq_mask;
   logic eof_evt, pause_evt, pause_evt_set;
   logic [31:0] frame_cnt;
   logic [CNT_W-1:0] pix_cnt, cnt_now, last_pixels;
   logic mm_wr, mm_rd, ctrl_wr, step_pulse;
   logic [31:0] status_clr, rd_mux;
   logic unused_wdata;

   assign unused_wdata = ^writedata;

   assign valid_out         = pv[PIPE_DEPTH-1];
   assign startofpacket_out = ps[PIPE_DEPTH-1];
   assign endofpacket_out   = pe[PIPE_DEPTH-1];
   assign data_out          = pd[PIPE_DEPTH-1];

   assign adv       = ready_in | ~valid_out;
   assign gate_open = (state != S_PAUSED);
   // reset term keeps ready low while reset is held, so nothing is accepted then
   assign ready_out = adv & gate_open & ~reset;
   assign acc       = valid_in & ready_out;
   assign acc_sop   = acc & startofpacket_in;
   assign acc_eop   = acc & endofpacket_in;

   assign mm_wr      = chipselect & write;
   assign mm_rd      = chipselect & read;
   assign ctrl_wr    = mm_wr & (address == 3'd0);
   assign step_pulse = ctrl_wr & writedata[1];
   assign status_clr = (mm_wr && address == 3'd1) ? writedata : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pv <= '0;
         ps <= '0;
         pe <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) pd[i] <= '0;
      end else if (adv) begin
         pv[0] <= acc;
         ps[0] <= acc_sop;
         pe[0] <= acc_eop;
         pd[0] <= data_in;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   // Decisions use the post-beat frame status so a sop accepted in the same
   // cycle as the pause request is never cut off.
   assign in_frame_nxt = acc_eop ? 1'b0 : (acc_sop ? 1'b1 : in_frame);

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:    if (pause_req) state_nxt = in_frame_nxt ? S_WAIT : S_PAUSED;
         S_WAIT:   if (!pause_req) state_nxt = S_RUN;
                   else if (acc_eop) state_nxt = S_PAUSED;
         S_PAUSED: if (step_pulse) state_nxt = S_STEP;
                   else if (!pause_req) state_nxt = S_RUN;
         S_STEP:   if (!pause_req) state_nxt = S_RUN;
                   else if (acc_eop && (step_frame || acc_sop)) state_nxt = S_PAUSED;
         default:  state_nxt = S_RUN;
      endcase
   end

   assign pause_evt_set = (state_nxt == S_PAUSED) && (state != S_PAUSED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_RUN;
         in_frame   <= 1'b0;
         step_frame <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_frame <= in_frame_nxt;
         if (state != S_STEP || acc_eop) step_frame <= 1'b0;
         else if (acc_sop)                step_frame <= 1'b1;
      end
   end

   assign cnt_now = acc_sop ? CNT_W'(1) : ((&pix_cnt) ? pix_cnt : pix_cnt + CNT_W'(1));

`ifdef VSG_SIZE_CHECK_EN
   logic        size_err, size_irq_en;
   logic [31:0] expect_pixels;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pause_req   <= 1'b0;
         irq_mask    <= 2'b00;
         eof_evt     <= 1'b0;
         pause_evt   <= 1'b0;
         frame_cnt   <= '0;
         pix_cnt     <= '0;
         last_pixels <= '0;
      end else begin
         if (ctrl_wr) begin
            pause_req <= writedata[0];
            irq_mask  <= writedata[9:8];
         end
         // set has priority over a same-cycle W1C
         eof_evt   <= acc_eop | (eof_evt & ~status_clr[0]);
         pause_evt <= pause_evt_set | (pause_evt & ~status_clr[1]);
         if (acc) pix_cnt <= acc_eop ? '0 : cnt_now;
         if (acc_eop) begin
            last_pixels <= cnt_now;
            frame_cnt   <= frame_cnt + 32'd1;
         end
      end
   end

`ifdef VSG_SIZE_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         size_err      <= 1'b0;
         size_irq_en   <= 1'b0;
         expect_pixels <= '0;
      end else begin
         if (ctrl_wr) size_irq_en <= writedata[10];
         if (mm_wr && address == 3'd4) expect_pixels <= writedata;
         size_err <= (acc_eop && expect_pixels != 32'd0 && 32'(cnt_now) != expect_pixels)
                   | (size_err & ~status_clr[3]);
      end
   end
   assign irq_sender = |({pause_evt, eof_evt} & irq_mask) | (size_err & size_irq_en);
`else
   assign irq_sender = |({pause_evt, eof_evt} & irq_mask);
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         3'd0: begin
            rd_mux[0]   = pause_req;
            rd_mux[9:8] = irq_mask;
`ifdef VSG_SIZE_CHECK_EN
            rd_mux[10]  = size_irq_en;
`endif
         end
         3'd1: begin
            rd_mux[0] = eof_evt;
            rd_mux[1] = pause_evt;
            rd_mux[2] = (state == S_PAUSED);
`ifdef VSG_SIZE_CHECK_EN
            rd_mux[3] = size_err;
`endif
         end
         3'd2: rd_mux = frame_cnt;
         3'd3: rd_mux = 32'(last_pixels);
`ifdef VSG_SIZE_CHECK_EN
         3'd4: rd_mux = expect_pixels;
`endif
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= mm_rd ? rd_mux : 32'd0;
   end

endmodule
